stdout_fifo: RTL and testbench

- Byte buffer between the brainfuck CPU's stdout/stdout_en output and the uart_tx transmitter.
- Replaces the ad-hoc edge-detect and start-stretch logic in the top level.
- Captures each CPU output byte, queues it, and replays it to uart_tx using the start/ready handshake.
- Throttles the CPU through cpu_en only when the queue is nearly full, so the CPU keeps running while the UART is busy.

---
 rtl/stdout_fifo_pkg.sv | 16 +
 rtl/stdout_fifo_sync_fifo.sv | 69 ++++++
 rtl/stdout_fifo.sv | 140 ++++++++++++++
 tb/tb_stdout_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdout_fifo_pkg.sv
// Shared types and constants for the stdout byte buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stdout_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        BUSY_LO = 2'd2,
        BUSY_HI = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

endpackage

// File: rtl/stdout_fifo_sync_fifo.sv
// Single-clock byte FIFO with occupancy count and sticky overflow flag.
// Latency: write visible at rd_data the cycle after push; rd_data is combinational from rd_ptr.
// Backpressure: none upstream; a push while full (and no pop) is dropped and flagged.
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_LVL);
    assign empty   = (count == '0);
    // A pop in the same cycle frees a slot, so a push at full is still accepted
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy separately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Dropped byte flag stays up until reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (push && !do_push) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/stdout_fifo.sv
// CPU stdout capture buffer feeding uart_tx via start/ready; STDOUT_FIFO_CRLF_EN expands LF into CR LF.
// Latency: stdout_en rise to count increment 3 clk edges; head byte loaded to tx_data one edge later if UART idle.
// Backpressure: cpu_en (registered) drops at count >= DEPTH-HOLD_MARGIN; UART stalls via tx_ready.
module stdout_fifo
    import stdout_fifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int START_CYCLES = 2,
    parameter int HOLD_MARGIN  = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [7:0]      stdout,
    input  logic            stdout_en,
    output logic            cpu_en,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    input  logic            tx_ready,
    output logic [ADDR_W:0] count,
    output logic            overflow
);

    localparam int              TMR_W      = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [ADDR_W:0] HOLD_LEVEL = (ADDR_W + 1)'(DEPTH - HOLD_MARGIN);

    logic             s1, s2, s3;
    logic             push;
    logic             pop;
    logic             load;
    logic [7:0]       head;
    logic [7:0]       load_byte;
    logic             fifo_empty;
    logic [TMR_W-1:0] timer;
    tx_state_t        state, state_nxt;
`ifdef STDOUT_FIFO_CRLF_EN
    logic             cr_done;
    logic             send_cr;
`endif

    // stdout_en comes from the CPU clock domain: two sync flops plus one for edge detect
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= stdout_en;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign push = s2 & ~s3;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .pop      (pop),
        .wr_data  (stdout),
        .rd_data  (head),
        .count    (count),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    // Transmit FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: load when data waits and UART idle, then follow the ready low/high handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty && tx_ready) state_nxt = START;
            START:   if (timer == '0)             state_nxt = BUSY_LO;
            BUSY_LO: if (!tx_ready)               state_nxt = BUSY_HI;
            BUSY_HI: if (tx_ready)                state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // FSM outputs; tx_start follows the START state so reset cuts it with no clock edge
    always_comb begin
        tx_start  = (state == START);
        load      = (state == IDLE) && !fifo_empty && tx_ready;
`ifdef STDOUT_FIFO_CRLF_EN
        send_cr   = load && (head == ASCII_LF) && !cr_done;
        load_byte = send_cr ? ASCII_CR : head;
        pop       = load && !send_cr;
`else
        load_byte = head;
        pop       = load;
`endif
    end

    // tx_data holds from one load to the next; timer counts the start pulse length
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_data <= 8'h00;
            timer   <= '0;
        end else if (load) begin
            tx_data <= load_byte;
            timer   <= TMR_W'(START_CYCLES - 1);
        end else if (state == START && timer != '0) begin
            timer   <= timer - 1'b1;
        end
    end

`ifdef STDOUT_FIFO_CRLF_EN
    // Remembers that the CR for the LF at the head has already gone out
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cr_done <= 1'b0;
        end else if (load) begin
            cr_done <= send_cr;
        end
    end
`endif

    // Stall the CPU early enough to absorb strobes still inside the synchronizer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu_en <= 1'b1;
        end else begin
            cpu_en <= (count < HOLD_LEVEL);
        end
    end

endmodule

// File: tb/tb_stdout_fifo.sv
module tb_stdout_fifo;

    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int START_CYCLES = 2;
    localparam int HOLD_MARGIN  = 2;

    logic            clk;
    logic            rstn;
    logic [7:0]      stdout;
    logic            stdout_en;
    logic            cpu_en;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_ready;
    logic [ADDR_W:0] count;
    logic            overflow;

    int         vectors;
    int         miscompares;
    int         busy;
    int         st_w;
    bit         uart_auto;
    logic [7:0] exp_q[$];

    stdout_fifo #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .START_CYCLES (START_CYCLES),
        .HOLD_MARGIN  (HOLD_MARGIN)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .stdout    (stdout),
        .stdout_en (stdout_en),
        .cpu_en    (cpu_en),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_ready  (tx_ready),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected byte stream as the UART should see it
    task automatic model_push(input logic [7:0] b);
`ifdef STDOUT_FIFO_CRLF_EN
        if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(b);
    endtask

    // One clock, then the UART model reacts and the start pulse width is checked
    task automatic tick();
        @(posedge clk);
        #1;
        if (tx_start) begin
            st_w++;
        end else if (st_w != 0) begin
            check("start_width", st_w, START_CYCLES);
            st_w = 0;
        end
        if (uart_auto) begin
            if (busy != 0) begin
                busy--;
                if (busy == 0) tx_ready = 1'b1;
            end else if (tx_start && tx_ready) begin
                check("tx_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("tx_order", tx_data, exp_q.pop_front());
                busy     = $urandom_range(3, 12);
                tx_ready = 1'b0;
            end
        end
    endtask

    task automatic strobe(input logic [7:0] b, input int hi, input int lo, input bit accept);
        stdout    = b;
        stdout_en = 1'b1;
        if (accept) model_push(b);
        repeat (hi) tick();
        stdout_en = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(tx_start && st_w == 1) && n < 200);
        check({tag, "_start_seen"}, tx_start, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        uart_auto = 1'b1;
        while ((exp_q.size() != 0 || count != 0 || busy != 0 || tx_start) && n < 4000) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_count0"}, count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0; miscompares = 0; busy = 0; st_w = 0; uart_auto = 1'b0;
        clk = 1'b0; rstn = 1'b1; stdout = 8'h00; stdout_en = 1'b0; tx_ready = 1'b1;

        // Reset state
        #1 rstn = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_cpu_en", cpu_en, 1);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // Single byte: 3-edge capture latency then a 2-cycle start pulse
        uart_auto = 1'b1;
        stdout = 8'h41; stdout_en = 1'b1; model_push(8'h41);
        tick(); tick();
        check("sb_count_2edges", count, 0);
        tick();
        check("sb_count_3edges", count, 1);
        stdout_en = 1'b0;
        tick();
        check("sb_tx_data", tx_data, 8'h41);
        check("sb_start_c1", tx_start, 1);
        check("sb_count_pop", count, 0);
        tick();
        check("sb_start_c2", tx_start, 1);
        tick();
        check("sb_start_end", tx_start, 0);
        drain("sb");

        // Backpressure: 14 bytes with the UART stalled
        uart_auto = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            strobe(i[7:0], 3, 2, 1'b1);
            if (i == 12) begin
                check("bp_count13", count, 13);
                check("bp_cpu_en13", cpu_en, 1);
            end
        end
        tick();
        check("bp_count14", count, 14);
        check("bp_cpu_en14", cpu_en, 0);
        uart_auto = 1'b1; tx_ready = 1'b1;
        begin
            int n = 0;
            while (count != 13 && n < 200) begin tick(); n++; end
        end
        check("bp_drop13", count, 13);
        check("bp_cpu_en_lag", cpu_en, 0);
        tick();
        check("bp_cpu_en_back", cpu_en, 1);
        drain("bp");

        // Overflow: 17 bytes into 16 slots
        uart_auto = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            strobe(8'h20 + i[7:0], 3, 2, i < 16);
        end
        tick(); tick();
        check("ovf_count16", count, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_cpu_en", cpu_en, 0);
        tx_ready = 1'b1;
        drain("ovf");
        check("ovf_sticky", overflow, 1);
        rstn = 1'b0;
        #1;
        check("ovf_cleared", overflow, 0);
        st_w = 0; busy = 0; tx_ready = 1'b1;
        @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // Push and pop on the same edge while full
        uart_auto = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            strobe(8'h40 + i[7:0], 3, 2, 1'b1);
        end
        tick(); tick();
        check("sim_count_full", count, 16);
        stdout = 8'h7E; stdout_en = 1'b1; model_push(8'h7E);
        tick(); tick();
        uart_auto = 1'b1; tx_ready = 1'b1;
        tick();
        check("sim_count_held", count, 16);
        check("sim_no_overflow", overflow, 0);
        tick();
        stdout_en = 1'b0;
        drain("sim");
        check("sim_overflow_end", overflow, 0);

        // Reset while tx_start is high; the queued byte must be discarded
        uart_auto = 1'b0; tx_ready = 1'b0;
        strobe(8'h55, 3, 2, 1'b1);
        strobe(8'h66, 3, 2, 1'b1);
        tick();
        uart_auto = 1'b1; tx_ready = 1'b1;
        wait_start("rst");
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_tx_start", tx_start, 0);
        check("rst_mid_count", count, 0);
        check("rst_mid_cpu_en", cpu_en, 1);
        exp_q.delete();
        st_w = 0; busy = 0; tx_ready = 1'b1;
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (30) tick();
        check("rst_mid_idle_count", count, 0);
        check("rst_mid_idle_start", tx_start, 0);

        // Line feed handling
        stdout = 8'h0A; stdout_en = 1'b1; model_push(8'h0A);
        wait_start("lf1");
        stdout_en = 1'b0;
`ifdef STDOUT_FIFO_CRLF_EN
        check("crlf_cr_byte", tx_data, 8'h0D);
        check("crlf_cr_count", count, 1);
        wait_start("lf2");
        check("crlf_lf_byte", tx_data, 8'h0A);
        check("crlf_lf_count", count, 0);
`else
        check("lf_byte", tx_data, 8'h0A);
        check("lf_count", count, 0);
`endif
        drain("lf");

        // Random traffic with a CPU that honours cpu_en
        for (int i = 0; i < 60; i++) begin
            int w = 0;
            while (!cpu_en && w < 500) begin tick(); w++; end
            check("rnd_cpu_en_wait", cpu_en, 1);
            strobe(8'($urandom_range(0, 255)), $urandom_range(3, 5), $urandom_range(2, 4), 1'b1);
        end
        drain("rnd");
        check("rnd_overflow", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
